// File: rtl/cim_array_sequencer.sv
// Compute-in-memory array sequencer.
// Accepts one command at a time (NOP/WRITE/READ/MAC) and sequences the array
// control strobes for it. All outputs decode from registered state only.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   cmd_valid, cmd_ready  command handshake (ready only while idle)
//   op_code               00 NOP, 01 WRITE, 10 READ, 11 MAC
//   addr                  {bank, row, col}, bank in the MSBs
//   data_in               write data or MAC operand
//   data_bank             array read-back data
//   mac_en, w_en          array MAC enable and write strobe
//   data_op               operand/write data to the array
//   bank_mux, col_mux     one-hot bank select, one-hot (or all-ones) column select
//   addr_row              row address (row counter during MAC)
//   rd_data, rd_valid     captured read data and its one-cycle valid pulse
//   done, busy            command-complete pulse, command in progress
module cim_array_sequencer #(
  parameter int NUM_BANKS = 16,
  parameter int ROWS      = 4,
  parameter int COLS      = 8,
  parameter int DATA_W    = 16,
  localparam int BW = $clog2(NUM_BANKS),
  localparam int RW = $clog2(ROWS),
  localparam int CW = $clog2(COLS),
  localparam int AW = BW + RW + CW
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           op_code,
  input  logic [AW-1:0]        addr,
  input  logic [DATA_W-1:0]    data_in,
  input  logic [DATA_W-1:0]    data_bank,
  output logic                 mac_en,
  output logic [DATA_W-1:0]    data_op,
  output logic [NUM_BANKS-1:0] bank_mux,
  output logic [RW-1:0]        addr_row,
  output logic [COLS-1:0]      col_mux,
  output logic                 w_en,
  output logic [DATA_W-1:0]    rd_data,
  output logic                 rd_valid,
  output logic                 done,
  output logic                 busy
);

  typedef enum logic [2:0] {StIdle, StWr, StRd, StRdCap, StMac} state_e;

  state_e              state_q, state_d;
  logic [RW-1:0]       mac_cnt_q, mac_cnt_d;
  logic [BW-1:0]       bank_q;
  logic [RW-1:0]       row_q;
  logic [CW-1:0]       col_q;
  logic [DATA_W-1:0]   data_q;
  logic [DATA_W-1:0]   rd_data_q;
  logic                rd_valid_q;

  logic accept;
  logic mac_last;

  assign accept   = cmd_valid && (state_q == StIdle);
  assign mac_last = (mac_cnt_q == RW'(ROWS - 1));

  // Next-state logic.
  always_comb begin
    state_d   = state_q;
    mac_cnt_d = mac_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          unique case (op_code)
            2'b01:   state_d = StWr;
            2'b10:   state_d = StRd;
            2'b11:   state_d = StMac;
            default: state_d = StIdle;
          endcase
        end
      end
      StWr:    state_d = StIdle;
      StRd:    state_d = StRdCap;
      StRdCap: state_d = StIdle;
      StMac: begin
        if (mac_last) begin
          state_d   = StIdle;
          mac_cnt_d = '0;
        end else begin
          mac_cnt_d = mac_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d   = StIdle;
        mac_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      mac_cnt_q  <= '0;
      bank_q     <= '0;
      row_q      <= '0;
      col_q      <= '0;
      data_q     <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mac_cnt_q  <= mac_cnt_d;
      rd_valid_q <= (state_q == StRdCap);
      if (state_q == StRdCap) begin
        rd_data_q <= data_bank;
      end
      // NOPs leave the captured fields untouched.
      if (accept && (op_code != 2'b00)) begin
        bank_q <= addr[AW-1 -: BW];
        row_q  <= addr[CW +: RW];
        col_q  <= addr[CW-1:0];
        data_q <= data_in;
      end
    end
  end

  // Output decode from registered state.
  always_comb begin
    mac_en   = 1'b0;
    w_en     = 1'b0;
    data_op  = '0;
    bank_mux = '0;
    addr_row = '0;
    col_mux  = '0;
    done     = rd_valid_q;
    unique case (state_q)
      StWr: begin
        w_en     = 1'b1;
        bank_mux = NUM_BANKS'(1) << bank_q;
        addr_row = row_q;
        col_mux  = COLS'(1) << col_q;
        data_op  = data_q;
        done     = 1'b1;
      end
      // Address stays applied through the capture cycle so data_bank is stable.
      StRd, StRdCap: begin
        bank_mux = NUM_BANKS'(1) << bank_q;
        addr_row = row_q;
        col_mux  = COLS'(1) << col_q;
      end
      StMac: begin
        mac_en   = 1'b1;
        bank_mux = NUM_BANKS'(1) << bank_q;
        addr_row = mac_cnt_q;
        col_mux  = '1;
        data_op  = data_q;
        done     = mac_last;
      end
      default: ;
    endcase
  end

  assign cmd_ready = (state_q == StIdle);
  assign busy      = ~cmd_ready;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;

endmodule

// File: tb/tb_cim_array_sequencer.sv
module tb_cim_array_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Default-parameter DUT.
  logic        cmd_valid, cmd_ready, mac_en, w_en, rd_valid, done, busy;
  logic [1:0]  op_code;
  logic [8:0]  addr;
  logic [15:0] data_in, data_bank, data_op, bank_mux, rd_data;
  logic [1:0]  addr_row;
  logic [7:0]  col_mux;

  // Swept-parameter DUT: NUM_BANKS=4, ROWS=8, COLS=4.
  logic        s_cmd_valid, s_cmd_ready, s_mac_en, s_w_en, s_rd_valid, s_done, s_busy;
  logic [1:0]  s_op_code;
  logic [6:0]  s_addr;
  logic [15:0] s_data_in, s_data_bank, s_data_op, s_rd_data;
  logic [3:0]  s_bank_mux;
  logic [2:0]  s_addr_row;
  logic [3:0]  s_col_mux;

  int total = 0;
  int bad   = 0;

  cim_array_sequencer dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .op_code(op_code), .addr(addr), .data_in(data_in), .data_bank(data_bank),
    .mac_en(mac_en), .data_op(data_op), .bank_mux(bank_mux), .addr_row(addr_row),
    .col_mux(col_mux), .w_en(w_en), .rd_data(rd_data), .rd_valid(rd_valid),
    .done(done), .busy(busy)
  );

  cim_array_sequencer #(.NUM_BANKS(4), .ROWS(8), .COLS(4), .DATA_W(16)) s_dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(s_cmd_valid), .cmd_ready(s_cmd_ready),
    .op_code(s_op_code), .addr(s_addr), .data_in(s_data_in), .data_bank(s_data_bank),
    .mac_en(s_mac_en), .data_op(s_data_op), .bank_mux(s_bank_mux),
    .addr_row(s_addr_row), .col_mux(s_col_mux), .w_en(s_w_en), .rd_data(s_rd_data),
    .rd_valid(s_rd_valid), .done(s_done), .busy(s_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; return 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    cmd_valid = 1'b0; op_code = 2'b00; addr = '0; data_in = '0; data_bank = '0;
    s_cmd_valid = 1'b0; s_op_code = 2'b00; s_addr = '0; s_data_in = '0; s_data_bank = '0;
    #3;
    chk("rst_ready", 32'(cmd_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_rd_data", 32'(rd_data), 0);
    chk("rst_bank_mux", 32'(bank_mux), 0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // WRITE 9'h1A5: bank field 4'hD, row 0, col 5.
    cmd_valid = 1'b1; op_code = 2'b01; addr = 9'h1A5; data_in = 16'hBEEF;
    step();
    cmd_valid = 1'b0;
    chk("wr_w_en", 32'(w_en), 1);
    chk("wr_bank_mux", 32'(bank_mux), 'h2000);
    chk("wr_addr_row", 32'(addr_row), 0);
    chk("wr_col_mux", 32'(col_mux), 'h20);
    chk("wr_data_op", 32'(data_op), 'hBEEF);
    chk("wr_done", 32'(done), 1);
    chk("wr_ready", 32'(cmd_ready), 0);
    chk("wr_busy", 32'(busy), 1);
    step();
    chk("wr_idle_w_en", 32'(w_en), 0);
    chk("wr_idle_bank", 32'(bank_mux), 0);
    chk("wr_idle_data_op", 32'(data_op), 0);
    chk("wr_idle_done", 32'(done), 0);
    chk("wr_idle_ready", 32'(cmd_ready), 1);

    // READ 9'h03F: bank 1, row 3, col 7.
    cmd_valid = 1'b1; op_code = 2'b10; addr = 9'h03F; data_in = 16'h5555;
    step();
    cmd_valid = 1'b0;
    chk("rd_bank_mux", 32'(bank_mux), 'h0002);
    chk("rd_addr_row", 32'(addr_row), 3);
    chk("rd_col_mux", 32'(col_mux), 'h80);
    chk("rd_w_en", 32'(w_en), 0);
    chk("rd_done", 32'(done), 0);
    data_bank = 16'h1234;
    step();
    chk("rdcap_done", 32'(done), 0);
    chk("rdcap_rd_valid", 32'(rd_valid), 0);
    step();
    data_bank = 16'h0000;
    chk("rd_rd_data", 32'(rd_data), 'h1234);
    chk("rd_rd_valid", 32'(rd_valid), 1);
    chk("rd_done3", 32'(done), 1);
    step();
    chk("rd_valid_drop", 32'(rd_valid), 0);
    chk("rd_done_drop", 32'(done), 0);
    chk("rd_data_hold", 32'(rd_data), 'h1234);

    // MAC 9'h1E0: bank 15, four cycles.
    cmd_valid = 1'b1; op_code = 2'b11; addr = 9'h1E0; data_in = 16'h00FF;
    step();
    cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("mac_en", 32'(mac_en), 1);
      chk("mac_row", 32'(addr_row), i);
      chk("mac_bank", 32'(bank_mux), 'h8000);
      chk("mac_col", 32'(col_mux), 'hFF);
      chk("mac_data_op", 32'(data_op), 'h00FF);
      chk("mac_done", 32'(done), 32'(i == 3));
      step();
    end
    chk("mac_end_en", 32'(mac_en), 0);
    chk("mac_end_done", 32'(done), 0);
    chk("mac_end_ready", 32'(cmd_ready), 1);

    // Back-to-back WRITE then MAC with cmd_valid held high.
    cmd_valid = 1'b1; op_code = 2'b01; addr = 9'h000; data_in = 16'h1111;
    step();
    op_code = 2'b11; addr = 9'h020; data_in = 16'h2222;
    chk("b2b_wr_w_en", 32'(w_en), 1);
    chk("b2b_wr_data", 32'(data_op), 'h1111);
    step();
    chk("b2b_idle_ready", 32'(cmd_ready), 1);
    chk("b2b_idle_mac", 32'(mac_en), 0);
    step();
    op_code = 2'b01; addr = 9'h1FF; data_in = 16'hDEAD;
    for (int i = 0; i < 4; i++) begin
      chk("b2b_mac_en", 32'(mac_en), 1);
      chk("b2b_mac_row", 32'(addr_row), i);
      chk("b2b_mac_bank", 32'(bank_mux), 'h0002);
      chk("b2b_mac_data", 32'(data_op), 'h2222);
      cmd_valid = (i == 3) ? 1'b0 : ~cmd_valid;
      step();
    end
    chk("b2b_end_w_en", 32'(w_en), 0);
    chk("b2b_end_mac", 32'(mac_en), 0);
    chk("b2b_end_ready", 32'(cmd_ready), 1);

    // Reset during the second MAC cycle.
    cmd_valid = 1'b1; op_code = 2'b11; addr = 9'h1E0; data_in = 16'h00FF;
    step();
    cmd_valid = 1'b0;
    step();
    chk("rst_mac_pre", 32'(addr_row), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("amid_mac_en", 32'(mac_en), 0);
    chk("amid_bank", 32'(bank_mux), 0);
    chk("amid_col", 32'(col_mux), 0);
    chk("amid_data_op", 32'(data_op), 0);
    chk("amid_done", 32'(done), 0);
    chk("amid_ready", 32'(cmd_ready), 1);
    chk("amid_rd_data", 32'(rd_data), 0);
    step();
    chk("amid_done_hold", 32'(done), 0);
    rst_n = 1'b1;
    cmd_valid = 1'b1; op_code = 2'b00; addr = 9'h1FF; data_in = 16'hFFFF;
    step();
    chk("nop_busy", 32'(busy), 0);
    chk("nop_done", 32'(done), 0);
    chk("nop_w_en", 32'(w_en), 0);
    chk("nop_mac", 32'(mac_en), 0);
    chk("nop_bank", 32'(bank_mux), 0);
    op_code = 2'b01; addr = 9'h0C5; data_in = 16'hA5A5;
    step();
    cmd_valid = 1'b0;
    chk("post_rst_w_en", 32'(w_en), 1);
    chk("post_rst_bank", 32'(bank_mux), 'h0040);
    chk("post_rst_col", 32'(col_mux), 'h20);
    step();

    // Swept parameters: MAC 7'h7F -> bank 3, eight rows counted from 0.
    s_cmd_valid = 1'b1; s_op_code = 2'b11; s_addr = 7'h7F; s_data_in = 16'h0F0F;
    step();
    s_cmd_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("s_mac_en", 32'(s_mac_en), 1);
      chk("s_mac_row", 32'(s_addr_row), i);
      chk("s_mac_bank", 32'(s_bank_mux), 'h8);
      chk("s_mac_col", 32'(s_col_mux), 'hF);
      chk("s_mac_done", 32'(s_done), 32'(i == 7));
      step();
    end
    chk("s_end_mac", 32'(s_mac_en), 0);
    chk("s_end_row", 32'(s_addr_row), 0);
    chk("s_end_ready", 32'(s_cmd_ready), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
